// File: rtl/uart_rx_frame_if.sv
// Line-side UART receiver port bundle.
// The line driver owns rx/work_fr; the receiver returns the decoded byte and status.
interface uart_rx_frame_if;
   localparam int unsigned DIV_W  = 12;
   localparam int unsigned DATA_W = 8;

   logic              rx;
   logic [DIV_W-1:0]  work_fr;
   logic [DATA_W-1:0] data_rx;
   logic              parity_rx;
   logic              parity_err;
   logic              frame_err;
   logic              ready;
   logic              busy;

   modport master (
      output rx, work_fr,
      input  data_rx, parity_rx, parity_err, frame_err, ready, busy
   );

   modport slave (
      input  rx, work_fr,
      output data_rx, parity_rx, parity_err, frame_err, ready, busy
   );
endinterface

// File: rtl/uart_rx_frame.sv
// UART frame receiver: 1 start, 8 data LSB-first, optional parity, 1 stop.
// Reports the received byte with parity and framing error flags on a one-cycle ready strobe.
module uart_rx_frame #(
   parameter bit          PARITY_EN   = 1'b1,
   parameter bit          PARITY_ODD  = 1'b0,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   uart_rx_frame_if.slave ifc
);
   localparam int unsigned DIV_W   = 12;
   localparam int unsigned DATA_W  = 8;
   localparam int unsigned IDX_W   = 3;
   localparam logic [DIV_W-1:0] DIV_MIN = DIV_W'(4);

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
   } state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s, rx_prev, fall, tick;
   logic [DIV_W-1:0]       div_in, div_q, div_n, cnt, cnt_n;
   logic [IDX_W-1:0]       idx, idx_n;
   logic [DATA_W-1:0]      shreg, shreg_n, data_q, data_n;
   logic                   par_q, par_n;
   logic                   prx_q, prx_n, perr_q, perr_n, ferr_q, ferr_n;
   logic                   ready_q, ready_n, busy_q, busy_n;

   // Metastability chain; presets to idle-high so reset never looks like a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync    <= '1;
         rx_prev <= 1'b1;
      end else begin
         sync    <= {sync[SYNC_STAGES-2:0], ifc.rx};
         rx_prev <= rx_s;
      end
   end

   assign rx_s   = sync[SYNC_STAGES-1];
   assign fall   = rx_prev & ~rx_s;
   assign tick   = (cnt == '0);
   assign div_in = (ifc.work_fr < DIV_MIN) ? DIV_MIN : ifc.work_fr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         div_q   <= DIV_MIN;
         cnt     <= '0;
         idx     <= '0;
         shreg   <= '0;
         par_q   <= 1'b0;
         data_q  <= '0;
         prx_q   <= 1'b0;
         perr_q  <= 1'b0;
         ferr_q  <= 1'b0;
         ready_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state   <= state_n;
         div_q   <= div_n;
         cnt     <= cnt_n;
         idx     <= idx_n;
         shreg   <= shreg_n;
         par_q   <= par_n;
         data_q  <= data_n;
         prx_q   <= prx_n;
         perr_q  <= perr_n;
         ferr_q  <= ferr_n;
         ready_q <= ready_n;
         busy_q  <= busy_n;
      end
   end

   // Bit timing: the counter runs down to zero, the FSM acts on zero and reloads
   always_comb begin
      state_n = state;
      div_n   = div_q;
      cnt_n   = cnt;
      idx_n   = idx;
      shreg_n = shreg;
      par_n   = par_q;
      data_n  = data_q;
      prx_n   = prx_q;
      perr_n  = perr_q;
      ferr_n  = ferr_q;
      ready_n = 1'b0;

      unique case (state)
         S_IDLE: begin
            if (fall) begin
               div_n   = div_in;
               cnt_n   = (div_in >> 1) - DIV_W'(1);
               state_n = S_START;
            end
         end
         S_START: begin
            if (!tick) begin
               cnt_n = cnt - DIV_W'(1);
            end else if (rx_s) begin
               state_n = S_IDLE;
            end else begin
               cnt_n   = div_q - DIV_W'(1);
               idx_n   = '0;
               state_n = S_DATA;
            end
         end
         S_DATA: begin
            if (!tick) begin
               cnt_n = cnt - DIV_W'(1);
            end else begin
               shreg_n[idx] = rx_s;
               cnt_n        = div_q - DIV_W'(1);
               idx_n        = idx + IDX_W'(1);
               if (idx == IDX_W'(DATA_W - 1)) begin
                  state_n = PARITY_EN ? S_PARITY : S_STOP;
               end
            end
         end
         S_PARITY: begin
            if (!tick) begin
               cnt_n = cnt - DIV_W'(1);
            end else begin
               par_n   = rx_s;
               cnt_n   = div_q - DIV_W'(1);
               state_n = S_STOP;
            end
         end
         S_STOP: begin
            if (!tick) begin
               cnt_n = cnt - DIV_W'(1);
            end else begin
               data_n  = shreg;
               prx_n   = PARITY_EN & par_q;
               perr_n  = PARITY_EN & ((^{shreg, par_q}) != PARITY_ODD);
               ferr_n  = ~rx_s;
               ready_n = 1'b1;
               state_n = rx_s ? S_IDLE : S_BREAK;
            end
         end
         S_BREAK: begin
            if (rx_s) begin
               state_n = S_IDLE;
            end
         end
         default: state_n = S_IDLE;
      endcase

      busy_n = (state_n != S_IDLE);
   end

   assign ifc.data_rx    = data_q;
   assign ifc.parity_rx  = prx_q;
   assign ifc.parity_err = perr_q;
   assign ifc.frame_err  = ferr_q;
   assign ifc.ready      = ready_q;
   assign ifc.busy       = busy_q;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed frames plus randomized frames
// compared against a frame-level reference model (content, flags and ready timing).
module tb_uart_rx_frame;
   localparam bit          PE = 1'b1;
   localparam bit          PO = 1'b0;
   localparam int unsigned SS = 2;

   logic clk = 1'b0;
   logic rst_n;

   uart_rx_frame_if ifc ();

   uart_rx_frame #(
      .PARITY_EN  (PE),
      .PARITY_ODD (PO),
      .SYNC_STAGES(SS)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .ifc  (ifc)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [7:0]  d;
      logic        p;
      logic        pe;
      logic        fe;
      int unsigned c;
   } rec_t;

   rec_t got_q[$];
   rec_t exp_q[$];

   int n_chk = 0;
   int n_err = 0;

   // Every ready cycle is logged; a stretched strobe shows up as an extra record
   always @(negedge clk) begin
      rec_t r;
      if (rst_n === 1'b1 && ifc.ready === 1'b1) begin
         r.d  = ifc.data_rx;
         r.p  = ifc.parity_rx;
         r.pe = ifc.parity_err;
         r.fe = ifc.frame_err;
         r.c  = cyc;
         got_q.push_back(r);
      end
   end

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic wait_cyc(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic idle(input int unsigned n);
      ifc.rx = 1'b1;
      wait_cyc(n);
   endtask

   task automatic drive_bit(input logic v, input int unsigned n);
      ifc.rx = v;
      wait_cyc(n);
   endtask

   function automatic logic even_fix(input logic [7:0] d);
      return logic'($countones(d) % 2) ^ PO;
   endfunction

   // Sends one frame starting now and queues what the receiver must report for it
   task automatic send_frame(input logic [7:0] d, input logic p, input logic stop,
                             input int unsigned wf);
      int unsigned dv;
      rec_t        e;
      dv            = (wf < 4) ? 4 : wf;
      ifc.work_fr   = 12'(wf);
      e.d  = d;
      e.p  = PE ? p : 1'b0;
      e.pe = PE && ((($countones(d) + int'(p)) % 2) != int'(PO));
      e.fe = ~stop;
      e.c  = cyc + SS + dv / 2 + (9 + (PE ? 1 : 0)) * dv + 1;
      exp_q.push_back(e);
      drive_bit(1'b0, dv);
      ifc.work_fr = 12'($urandom);
      for (int i = 0; i < 8; i++) drive_bit(d[i], dv);
      if (PE) drive_bit(p, dv);
      drive_bit(stop, dv);
   endtask

   task automatic expect_frames(input string tag);
      int unsigned w;
      rec_t        g, e;
      w = 0;
      while (got_q.size() < exp_q.size() && w < 3000) begin
         wait_cyc(1);
         w++;
      end
      wait_cyc(8);
      check({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
      while (exp_q.size() > 0 && got_q.size() > 0) begin
         g = got_q.pop_front();
         e = exp_q.pop_front();
         check({tag, " data"},  32'(g.d),  32'(e.d));
         check({tag, " par"},   32'(g.p),  32'(e.p));
         check({tag, " perr"},  32'(g.pe), 32'(e.pe));
         check({tag, " ferr"},  32'(g.fe), 32'(e.fe));
         check({tag, " ready cycle"}, g.c, e.c);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " data"},  32'(ifc.data_rx),    32'h00);
      check({tag, " par"},   32'(ifc.parity_rx),  32'h0);
      check({tag, " perr"},  32'(ifc.parity_err), 32'h0);
      check({tag, " ferr"},  32'(ifc.frame_err),  32'h0);
      check({tag, " ready"}, 32'(ifc.ready),      32'h0);
      check({tag, " busy"},  32'(ifc.busy),       32'h0);
   endtask

   initial begin
      logic [7:0]  d;
      logic [7:0]  part;
      logic        p, stop;
      int unsigned wf, dv;

      ifc.rx      = 1'b1;
      ifc.work_fr = 12'd16;
      rst_n       = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      check_reset_outputs("reset");
      wait_cyc(3);
      rst_n = 1'b1;
      idle(5);

      // Correct even parity, then a deliberately wrong parity bit
      send_frame(8'hA5, 1'b0, 1'b1, 16);
      idle(4);
      expect_frames("a5");
      send_frame(8'h01, 1'b0, 1'b1, 16);
      idle(4);
      expect_frames("01 bad par");

      // Stop bit low, line held in break, then released
      send_frame(8'h3C, 1'b0, 1'b0, 16);
      wait_cyc(40);
      check("break busy", 32'(ifc.busy), 32'h1);
      check("break single ready", 32'(got_q.size()), 32'h1);
      idle(5);
      check("break released busy", 32'(ifc.busy), 32'h0);
      expect_frames("3c break");

      // Short low glitch is a false start
      ifc.work_fr = 12'd16;
      drive_bit(1'b0, 3);
      idle(2);
      check("glitch busy", 32'(ifc.busy), 32'h1);
      idle(15);
      check("glitch busy clear", 32'(ifc.busy), 32'h0);
      check("glitch no ready", 32'(got_q.size()), 32'h0);

      // Back-to-back at the clamped divisor and below it
      send_frame(8'h00, even_fix(8'h00), 1'b1, 4);
      send_frame(8'hFF, even_fix(8'hFF), 1'b1, 4);
      idle(2);
      send_frame(8'h00, even_fix(8'h00), 1'b1, 2);
      send_frame(8'hFF, even_fix(8'hFF), 1'b1, 2);
      idle(2);
      expect_frames("b2b");

      // Reset in the middle of bit 4 aborts the frame
      part        = 8'hC3;
      ifc.work_fr = 12'd16;
      drive_bit(1'b0, 16);
      for (int i = 0; i < 4; i++) drive_bit(part[i], 16);
      drive_bit(part[4], 8);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid reset");
      ifc.rx = 1'b1;
      wait_cyc(3);
      rst_n = 1'b1;
      idle(40);
      check("mid reset no ready", 32'(got_q.size()), 32'h0);
      check("mid reset busy", 32'(ifc.busy), 32'h0);
      send_frame(8'h5A, even_fix(8'h5A), 1'b1, 16);
      idle(4);
      expect_frames("5a");

      // Randomized frames: divisors around the clamp, occasional bad parity/stop
      for (int k = 0; k < 12; k++) begin
         d    = 8'($urandom);
         wf   = $urandom_range(2, 20);
         dv   = (wf < 4) ? 4 : wf;
         p    = even_fix(d) ^ ($urandom_range(0, 3) == 0);
         stop = ($urandom_range(0, 4) != 0);
         send_frame(d, p, stop, wf);
         if (!stop) idle(dv + 6);
         else       idle($urandom_range(0, 3));
      end
      idle(4);
      expect_frames("rand");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL timeout: got no finish, want finish");
      $fatal(1, "timeout");
   end
endmodule
